// File: rtl/audio_mixer.sv
// Multi-channel PCM mixer: fetches one sample per channel, applies per-channel
// gain with optional fade-out, sums, saturates and writes the result to a FIFO.
module audio_mixer #(
  parameter int pChNum    = 3,
  parameter int pBitDepth = 16,
  parameter int pVolWidth = 8,
  parameter int pFadeDec  = 1
) (
  input  logic                           iSCLK,
  input  logic                           iSRST,
  input  logic                           iEn,
  input  logic [pChNum*pBitDepth-1:0]    iChRd,
  input  logic [pChNum-1:0]              iChRvd,
  output logic [pChNum-1:0]              oChRe,
  input  logic [pChNum*pVolWidth-1:0]    iVol,
  input  logic [pChNum-1:0]              iFadeReq,
  output logic [pChNum-1:0]              oFadeDone,
  output logic signed [pBitDepth-1:0]    oWd,
  output logic                           oWe,
  input  logic                           iFull,
  input  logic                           iAlert,
  output logic                           oClip,
  input  logic                           iClipClr,
  output logic                           oBusy
);

  localparam int AccW  = pBitDepth + 2 + $clog2(pChNum);
  localparam int ProdW = pBitDepth + pVolWidth + 1;
  localparam int IdxW  = (pChNum > 1) ? $clog2(pChNum) : 1;
  localparam logic [IdxW-1:0]        LastIdx = IdxW'(pChNum - 1);
  localparam logic [pVolWidth-1:0]   FadeDec = pVolWidth'(pFadeDec);
  localparam logic signed [AccW-1:0] SatMax  = {{(AccW-pBitDepth+1){1'b0}}, {(pBitDepth-1){1'b1}}};
  localparam logic signed [AccW-1:0] SatMin  = ~SatMax;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_CAP  = 3'd2;
  localparam logic [2:0] S_ACC  = 3'd3;
  localparam logic [2:0] S_OUT  = 3'd4;

  logic [2:0]                  state_q, state_d;
  logic [IdxW-1:0]             idx_q;
  logic signed [AccW-1:0]      acc_q;
  logic signed [pBitDepth-1:0] smp_q [pChNum];
  logic [pVolWidth-1:0]        gain_q [pChNum];
  logic signed [pBitDepth-1:0] wd_q;
  logic                        we_q;
  logic                        clip_q;
  logic [pChNum-1:0]           done_q;
  logic                        wr;

  // Gain of 128 is unity, so the product is scaled down by 2^7 with floor rounding.
  function automatic logic signed [AccW-1:0] scale(input logic signed [pBitDepth-1:0] s,
                                                   input logic [pVolWidth-1:0] g);
    logic signed [ProdW-1:0] p;
    p = s * $signed({1'b0, g});
    return AccW'(p >>> 7);
  endfunction

  function automatic logic sat_hit(input logic signed [AccW-1:0] a);
    return (a > SatMax) || (a < SatMin);
  endfunction

  function automatic logic signed [pBitDepth-1:0] sat_val(input logic signed [AccW-1:0] a);
    if (a > SatMax)      return SatMax[pBitDepth-1:0];
    else if (a < SatMin) return SatMin[pBitDepth-1:0];
    else                 return a[pBitDepth-1:0];
  endfunction

  function automatic logic [pVolWidth-1:0] fade_next(input logic [pVolWidth-1:0] g);
    return (g >= FadeDec) ? g - FadeDec : '0;
  endfunction

  assign wr        = (state_q == S_OUT) && !iFull;
  assign oChRe     = {pChNum{state_q == S_REQ}};
  assign oBusy     = (state_q != S_IDLE);
  assign oWd       = wd_q;
  assign oWe       = we_q;
  assign oClip     = clip_q;
  assign oFadeDone = done_q;

  // OUT chains straight into REQ when enabled so back-to-back samples take 3+pChNum cycles.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (iEn && !iAlert) state_d = S_REQ;
      S_REQ:   state_d = S_CAP;
      S_CAP:   state_d = S_ACC;
      S_ACC:   if (idx_q == LastIdx) state_d = S_OUT;
      S_OUT:   if (!iFull) state_d = (iEn && !iAlert) ? S_REQ : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iSCLK or posedge iSRST) begin
    if (iSRST) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      wd_q    <= '0;
      we_q    <= 1'b0;
      clip_q  <= 1'b0;
      done_q  <= '0;
      for (int x = 0; x < pChNum; x++) gain_q[x] <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= wr;
      done_q  <= '0;
      if (iClipClr) clip_q <= 1'b0;
      if (wr && sat_hit(acc_q)) clip_q <= 1'b1;
      if (state_q == S_CAP) begin
        acc_q <= '0;
        idx_q <= '0;
        for (int x = 0; x < pChNum; x++)
          if (!iFadeReq[x]) gain_q[x] <= iVol[x*pVolWidth +: pVolWidth];
      end
      if (state_q == S_ACC) begin
        acc_q <= acc_q + scale(smp_q[idx_q], gain_q[idx_q]);
        idx_q <= idx_q + 1'b1;
      end
      if (wr) begin
        wd_q <= sat_val(acc_q);
        for (int x = 0; x < pChNum; x++)
          if (iFadeReq[x]) begin
            gain_q[x] <= fade_next(gain_q[x]);
            done_q[x] <= (gain_q[x] != '0) && (fade_next(gain_q[x]) == '0);
          end
      end
    end
  end

  // Sample holding registers carry data only; invalid channels are captured as silence.
  always_ff @(posedge iSCLK) begin
    if (state_q == S_CAP)
      for (int x = 0; x < pChNum; x++)
        smp_q[x] <= iChRvd[x] ? iChRd[x*pBitDepth +: pBitDepth] : '0;
  end

endmodule

// File: tb/tb_audio_mixer.sv
// Bench for audio_mixer: directed scenarios plus randomized mixes, all checked
// against a sample-level arithmetic model of gain, sum, saturation and fade.
module tb_audio_mixer;

  localparam int N   = 3;
  localparam int BD  = 16;
  localparam int VW  = 8;
  localparam int DEC = 1;

  logic                   clk = 1'b0;
  logic                   iSRST, iEn, iFull, iAlert, iClipClr;
  logic [N*BD-1:0]        iChRd;
  logic [N-1:0]           iChRvd, oChRe, iFadeReq, oFadeDone;
  logic [N*VW-1:0]        iVol;
  logic signed [BD-1:0]   oWd;
  logic                   oWe, oClip, oBusy;

  always #5 clk = ~clk;

  audio_mixer #(.pChNum(N), .pBitDepth(BD), .pVolWidth(VW), .pFadeDec(DEC)) dut (
    .iSCLK(clk), .iSRST(iSRST), .iEn(iEn), .iChRd(iChRd), .iChRvd(iChRvd),
    .oChRe(oChRe), .iVol(iVol), .iFadeReq(iFadeReq), .oFadeDone(oFadeDone),
    .oWd(oWd), .oWe(oWe), .iFull(iFull), .iAlert(iAlert), .oClip(oClip),
    .iClipClr(iClipClr), .oBusy(oBusy)
  );

  int checks = 0;
  int errors = 0;

  // Per-transaction stimulus
  int         t_s [N];
  int         t_vol [N];
  logic [N-1:0] t_vld, t_frc, t_frw;
  logic       t_clr;
  int         t_full;
  logic       t_chk;
  int         t_exp;

  // Reference model state
  int   mg [N];
  logic mclip;
  int   mwd;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int fdiv128(input int p);
    if (p >= 0) return p / 128;
    return -((-p + 127) / 128);
  endfunction

  task automatic model_reset();
    for (int x = 0; x < N; x++) mg[x] = 0;
    mclip = 1'b0;
    mwd   = 0;
  endtask

  task automatic model_step(output int exp_wd, output logic [N-1:0] exp_done);
    int   sum, ng;
    logic sat;
    sum = 0;
    exp_done = '0;
    for (int x = 0; x < N; x++) if (!t_frc[x]) mg[x] = t_vol[x];
    for (int x = 0; x < N; x++) if (t_vld[x]) sum += fdiv128(t_s[x] * mg[x]);
    sat = (sum > 32767) || (sum < -32768);
    exp_wd = sat ? ((sum > 0) ? 32767 : -32768) : sum;
    mclip = t_clr ? sat : (mclip | sat);
    for (int x = 0; x < N; x++)
      if (t_frw[x]) begin
        ng = mg[x] - DEC;
        if (ng < 0) ng = 0;
        exp_done[x] = (mg[x] != 0) && (ng == 0);
        mg[x] = ng;
      end
    mwd = exp_wd;
  endtask

  task automatic drive_inputs();
    for (int x = 0; x < N; x++) begin
      iChRd[x*BD +: BD] = t_s[x][BD-1:0];
      iVol[x*VW +: VW]  = t_vol[x][VW-1:0];
    end
    iChRvd   = t_vld;
    iFadeReq = t_frc;
    iClipClr = t_clr;
    iFull    = (t_full > 0);
  endtask

  task automatic wait_req(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (oChRe !== {N{1'b1}} && n < 20);
  endtask

  task automatic set3(input int s0, input int s1, input int s2, input int v0, input int v1, input int v2);
    t_s[0] = s0; t_s[1] = s1; t_s[2] = s2;
    t_vol[0] = v0; t_vol[1] = v1; t_vol[2] = v2;
  endtask

  task automatic run_sample(input string tag);
    int           lat, n, exp_wd;
    logic [N-1:0] exp_done;
    logic         we_seen, wd_moved;
    drive_inputs();
    iEn = 1'b1;
    wait_req(n);
    check({tag, "_req"}, oChRe, {N{1'b1}});
    iEn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    iFadeReq = t_frw;
    lat = 2;
    if (t_full > 0) begin
      we_seen  = 1'b0;
      wd_moved = 1'b0;
      repeat (3 + t_full) begin
        @(negedge clk);
        lat++;
        if (oWe !== 1'b0) we_seen = 1'b1;
        if (oWd !== 16'(mwd)) wd_moved = 1'b1;
      end
      check({tag, "_stall_we"}, we_seen, 1'b0);
      check({tag, "_stall_wd"}, wd_moved, 1'b0);
      check({tag, "_stall_busy"}, oBusy, 1'b1);
      iFull = 1'b0;
    end
    do begin @(negedge clk); lat++; end while (oWe !== 1'b1 && lat < 40 + t_full);
    check({tag, "_we"}, oWe, 1'b1);
    if (t_full == 0) check({tag, "_lat"}, lat, 6);
    model_step(exp_wd, exp_done);
    check({tag, "_wd"}, oWd, exp_wd);
    if (t_chk) check({tag, "_wd_const"}, oWd, t_exp);
    check({tag, "_clip"}, oClip, mclip);
    check({tag, "_fdone"}, oFadeDone, exp_done);
    iClipClr = 1'b0;
    @(negedge clk);
    check({tag, "_we_once"}, oWe, 1'b0);
    check({tag, "_fdone_once"}, oFadeDone, '0);
  endtask

  initial begin
    int           n, exp_wd;
    logic [N-1:0] exp_done;
    logic         flag;

    iSRST = 1'b1; iEn = 1'b0; iFull = 1'b0; iAlert = 1'b0; iClipClr = 1'b0;
    iChRd = '0; iChRvd = '0; iVol = '0; iFadeReq = '0;
    t_vld = '0; t_frc = '0; t_frw = '0; t_clr = 1'b0; t_full = 0; t_chk = 1'b0; t_exp = 0;
    set3(0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_busy", oBusy, 1'b0);
    check("rst_re", oChRe, '0);
    check("rst_we", oWe, 1'b0);
    check("rst_wd", oWd, 0);
    check("rst_clip", oClip, 1'b0);
    check("rst_fdone", oFadeDone, '0);
    iSRST = 1'b0;
    flag = 1'b0;
    repeat (5) begin @(negedge clk); if (oWe !== 1'b0 || oBusy !== 1'b0) flag = 1'b1; end
    check("post_rst_quiet", flag, 1'b0);

    // Unity mix
    set3(1000, 2000, -500, 128, 128, 128);
    t_vld = 3'b111; t_chk = 1'b1; t_exp = 2500;
    run_sample("unity");

    // Saturation both ways
    set3(30000, 30000, 0, 128, 128, 128);
    t_exp = 32767;
    run_sample("sat_pos");
    set3(-30000, -30000, 0, 128, 128, 128);
    t_exp = -32768;
    run_sample("sat_neg");

    // Clip clear, then clear and new clip together
    @(negedge clk); iClipClr = 1'b1; @(negedge clk); iClipClr = 1'b0;
    mclip = 1'b0;
    check("clip_clr", oClip, 1'b0);
    set3(30000, 30000, 0, 128, 128, 128);
    t_clr = 1'b1; t_exp = 32767;
    run_sample("clip_set_wins");
    t_clr = 1'b0;

    // Half gain, floor rounding
    set3(1001, 0, 0, 64, 0, 0);
    t_vld = 3'b001; t_exp = 500;
    run_sample("half_pos");
    t_s[0] = -1001; t_exp = -501;
    run_sample("half_neg");

    // Invalid channel contributes silence
    set3(1000, 2000, -500, 128, 128, 128);
    t_vld = 3'b101; t_exp = 500;
    run_sample("ch1_invalid");

    // FIFO full for a while in OUT
    set3(100, 200, 300, 128, 128, 128);
    t_vld = 3'b111; t_full = 10; t_exp = 600;
    run_sample("full_stall");
    t_full = 0;

    // Alert blocks new requests
    iAlert = 1'b1; iEn = 1'b1; flag = 1'b0;
    repeat (10) begin @(negedge clk); if (oChRe !== '0 || oBusy !== 1'b0) flag = 1'b1; end
    check("alert_blocks", flag, 1'b0);
    iEn = 1'b0; iAlert = 1'b0;
    @(negedge clk);

    // Fade-out on channel 0, then abort
    set3(1000, 0, 0, 4, 0, 0);
    t_vld = 3'b001; t_frc = 3'b000; t_frw = 3'b001; t_exp = 31;
    run_sample("fade1");
    t_frc = 3'b001;
    t_exp = 23; run_sample("fade2");
    t_exp = 15; run_sample("fade3");
    t_exp = 7;  run_sample("fade4");
    t_exp = 0;  run_sample("fade5");
    t_exp = 0;  run_sample("fade6");
    t_frc = 3'b000; t_frw = 3'b000; t_exp = 31;
    run_sample("fade_abort");

    // Back-to-back period with enable held
    set3(100, 200, 300, 128, 128, 128);
    t_vld = 3'b111; t_clr = 1'b0;
    drive_inputs();
    iEn = 1'b1;
    wait_req(n);
    check("b2b_req", oChRe, {N{1'b1}});
    n = 0;
    do begin @(negedge clk); n++; end while (oChRe !== {N{1'b1}} && n < 20);
    check("b2b_period", n, 6);
    check("b2b_we1", oWe, 1'b1);
    model_step(exp_wd, exp_done);
    check("b2b_wd1", oWd, exp_wd);
    iEn = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (oWe !== 1'b1 && n < 20);
    check("b2b_lat2", n, 6);
    model_step(exp_wd, exp_done);
    check("b2b_wd2", oWd, exp_wd);
    @(negedge clk);
    check("b2b_idle", oBusy, 1'b0);

    // Asynchronous reset in the middle of accumulation
    set3(30000, 30000, 0, 128, 128, 128);
    t_exp = 32767;
    run_sample("pre_rst");
    drive_inputs();
    iEn = 1'b1;
    wait_req(n);
    iEn = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", oBusy, 1'b1);
    check("pre_rst_clip", oClip, 1'b1);
    #1 iSRST = 1'b1;
    #1;
    check("arst_busy", oBusy, 1'b0);
    check("arst_re", oChRe, '0);
    check("arst_we", oWe, 1'b0);
    check("arst_wd", oWd, 0);
    check("arst_clip", oClip, 1'b0);
    check("arst_fdone", oFadeDone, '0);
    @(negedge clk);
    @(negedge clk);
    iSRST = 1'b0;
    model_reset();
    flag = 1'b0;
    repeat (6) begin @(negedge clk); if (oWe !== 1'b0 || oChRe !== '0) flag = 1'b1; end
    check("arst_quiet", flag, 1'b0);

    // Gains are zero after reset while held by a fade request
    set3(1000, 2000, -500, 128, 128, 128);
    t_frc = 3'b111; t_frw = 3'b000; t_exp = 0;
    run_sample("gain_rst");
    t_frc = 3'b000; t_exp = 2500;
    run_sample("gain_reload");

    // Randomized mixes
    t_chk = 1'b0;
    for (int i = 0; i < 40; i++) begin
      for (int x = 0; x < N; x++) begin
        t_s[x]   = int'($signed(16'($urandom)));
        t_vol[x] = int'($urandom_range(0, 255));
      end
      t_vld  = N'($urandom_range(0, 7));
      t_clr  = ($urandom_range(0, 3) == 0);
      t_full = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
      t_frc  = '0;
      t_frw  = '0;
      run_sample("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_mixer.md
AUDIO_MIXER -- requirements
Module: audio_mixer

Interface
REQ-001 SHALL have parameter pChNum, default 3, number of PCM input channels.
REQ-002 SHALL have parameter pBitDepth, default 16, signed sample width.
REQ-003 SHALL have parameter pVolWidth, default 8, unsigned per-channel gain width; 128 = unity.
REQ-004 SHALL have parameter pFadeDec, default 1, gain decrement per output sample while fading.
REQ-005 iSCLK  in  1  sole clock, all logic on rising edge.
REQ-006 iSRST  in  1  reset, asynchronous, active-high.
REQ-007 iEn  in  1  mixer enable.
REQ-008 iChRd  in  pChNum*pBitDepth  per-channel signed samples from ROM readers, channel x at [(x+1)*16-1 : x*16].
REQ-009 iChRvd  in  pChNum  per-channel sample valid, one cycle after oChRe.
REQ-010 oChRe  out  pChNum  read-enable pulse to all channel readers.
REQ-011 iVol  in  pChNum*pVolWidth  per-channel gain from CSR.
REQ-012 iFadeReq  in  pChNum  level, fade-out request per channel.
REQ-013 oFadeDone  out  pChNum  one-cycle pulse when channel gain reaches 0.
REQ-014 oWd  out  pBitDepth  mixed signed sample to async FIFO.
REQ-015 oWe  out  1  FIFO write strobe.
REQ-016 iFull, iAlert  in  1 each  FIFO full / remaining-count alert.
REQ-017 oClip  out  1  sticky saturation flag; iClipClr  in  1  clears it.
REQ-018 oBusy  out  1  high whenever FSM is not IDLE.

Function
REQ-019 FSM states SHALL be IDLE, REQ, CAP, ACC, OUT.
REQ-020 IDLE->REQ when iEn=1 and iAlert=0; otherwise stay IDLE.
REQ-021 REQ: oChRe all ones for exactly this cycle, then CAP.
REQ-022 CAP: latch iChRd per channel; channel with iChRvd=0 latched as 0; clear accumulator; then ACC.
REQ-023 ACC: one channel per cycle, index 0..pChNum-1, accumulate (sample * {0,gain}) >>> 7 (arithmetic shift, floor); after pChNum cycles go OUT.
REQ-024 Accumulator width SHALL be pBitDepth+2+clog2(pChNum) bits, no internal overflow.
REQ-025 OUT: saturate accumulator to [-2^(pBitDepth-1), 2^(pBitDepth-1)-1]; set oClip if saturation occurred.
REQ-026 OUT with iFull=0: oWd registered, oWe=1 for one cycle, then IDLE; with iFull=1: oWe=0, oWd held, remain in OUT.
REQ-027 Minimum period SHALL be 3+pChNum cycles per output sample (6 at default).
REQ-028 iEn deassert mid-sequence SHALL complete current sample, then stay IDLE.
REQ-029 Per-channel gain register: iFadeReq=0 -> loads iVol in CAP; iFadeReq=1 -> holds, decremented by pFadeDec at each completed write, floor at 0.
REQ-030 oFadeDone[x] pulses one cycle after the write that takes gain[x] from nonzero to 0; gain held 0 while iFadeReq[x]=1.
REQ-031 iFadeReq[x] dropped mid-fade SHALL abort fade; gain reloads iVol at next CAP.
REQ-032 iClipClr and a new clip same cycle: oClip SHALL be 1 (set wins).

Reset
REQ-033 On iSRST=1: state IDLE, oChRe=0, oWe=0, oWd=0, oFadeDone=0, oClip=0, oBusy=0, gains=0, accumulator=0, immediately and asynchronously.
REQ-034 After reset release, no oWe before a full REQ..OUT sequence.

Verification
REQ-035 iVol all 128, samples 1000, 2000, -500, iFull=0 -> oWd=2500, oWe one pulse, 6 cycles from IDLE exit.
REQ-036 Samples 30000, 30000, 0 at 128 -> oWd=32767, oClip=1; -30000, -30000, 0 -> -32768.
REQ-037 Ch0 only, iVol=64: sample 1001 -> 500; sample -1001 -> -501.
REQ-038 Ch0 iVol=4, iFadeReq=1, sample 1000 constant -> oWd 31, 23, 15, 7, 0, 0; oFadeDone[0] pulse once after 4th write.
REQ-039 iFull=1 for 10 cycles in OUT -> oWe=0, oWd stable, exactly one write on release; iAlert=1 in IDLE -> no oChRe.
REQ-040 iSRST pulse during ACC -> all outputs 0 same cycle; iChRvd=0 on ch1 -> ch1 contributes 0.
